// File: rtl/ws2812b_pkg.sv
// Shared WS2812B types and 12 MHz line timing, common to the receiver and the transmitter.
package ws2812b_pkg;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  localparam int T0H     = 5;
  localparam int T1H     = 10;
  localparam int T_BIT   = 15;
  localparam int T_RESET = 600;

  localparam int PIX_BITS = 24;

  // Decode threshold midway between the two nominal highs; glitch and overrun limits bracket them.
  localparam int BIT_THRESH_DEF = (T0H + T1H + 1) / 2;
  localparam int MIN_HIGH_DEF   = T0H / 2;
  localparam int MAX_HIGH_DEF   = T1H + T0H - 1;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LOW,
    ST_HIGH
  } rx_state_e;

endpackage

// File: rtl/ws2812b_sync_edge.sv
// Two-flop synchronizer for the serial line plus registered rise/fall strobes.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rise_q <= s2_q & ~prev_q;
      fall_q <= ~s2_q & prev_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B line receiver: measures high pulses, assembles 24-bit GRB pixels, detects the latch gap.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int BIT_THRESH   = BIT_THRESH_DEF,
  parameter int MIN_HIGH     = MIN_HIGH_DEF,
  parameter int MAX_HIGH     = MAX_HIGH_DEF,
  parameter int RESET_CYCLES = T_RESET,
  parameter int MAX_PIXELS   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din,
  output pixel_t                        pixel,
  output logic                          pixel_valid,
  output logic [$clog2(MAX_PIXELS)-1:0] pixel_index,
  output logic                          frame_done,
  output logic [$clog2(MAX_PIXELS):0]   pixel_count,
  output logic                          err
);

  localparam int IDX_W = $clog2(MAX_PIXELS);
  localparam int CNT_W = IDX_W + 1;
  localparam int LO_W  = $clog2(RESET_CYCLES + 1);
  localparam int HI_W  = $clog2(MAX_HIGH + 2);
  localparam int BIT_W = $clog2(PIX_BITS);

  localparam logic [LO_W-1:0]  LO_LAST  = LO_W'(RESET_CYCLES - 1);
  localparam logic [LO_W-1:0]  LO_FULL  = LO_W'(RESET_CYCLES);
  localparam logic [HI_W-1:0]  HI_SAT   = '1;
  localparam logic [HI_W-1:0]  HI_MIN   = HI_W'(MIN_HIGH);
  localparam logic [HI_W-1:0]  HI_MAX   = HI_W'(MAX_HIGH);
  localparam logic [HI_W-1:0]  HI_THR   = HI_W'(BIT_THRESH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIX_BITS - 1);
  localparam logic [CNT_W-1:0] PIX_MAX  = CNT_W'(MAX_PIXELS);

  logic lvl, rise, fall;

  sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (din),
    .lvl_o  (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  rx_state_e            state_q, state_d;
  logic [LO_W-1:0]      lo_cnt_q, lo_cnt_d;
  logic [HI_W-1:0]      hi_cnt_q, hi_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [PIX_BITS-1:0]  shift_q, shift_d;
  pixel_t               pixel_q, pixel_d;
  logic [IDX_W-1:0]     pixel_index_q, pixel_index_d;
  logic [CNT_W-1:0]     pixel_count_q, pixel_count_d;
  logic                 pixel_valid_q, pixel_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_q, err_d;
  logic                 err_set;
  logic [HI_W-1:0]      hi_len;
  logic                 bit_val;
  logic [PIX_BITS-1:0]  shift_nxt;

  // hi_len is the high width including the current cycle; rise and fall strobes share the same delay.
  always_comb begin
    state_d       = state_q;
    lo_cnt_d      = lo_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    shift_d       = shift_q;
    pixel_d       = pixel_q;
    pixel_index_d = pixel_index_q;
    pixel_count_d = pixel_count_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    err_set       = 1'b0;
    hi_len        = (hi_cnt_q == HI_SAT) ? hi_cnt_q : hi_cnt_q + HI_W'(1);
    bit_val       = (hi_len >= HI_THR);
    shift_nxt     = {shift_q[PIX_BITS-2:0], bit_val};

    unique case (state_q)
      ST_SYNC: begin
        if (lvl) begin
          lo_cnt_d = '0;
        end else if (lo_cnt_q == LO_LAST) begin
          state_d   = ST_LOW;
          lo_cnt_d  = LO_FULL;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
        end else begin
          lo_cnt_d = lo_cnt_q + LO_W'(1);
        end
      end

      ST_LOW: begin
        if (lo_cnt_q == LO_LAST) begin
          if (pix_cnt_q != '0) begin
            frame_done_d  = 1'b1;
            pixel_count_d = pix_cnt_q;
          end
          if (bit_cnt_q != '0) err_set = 1'b1;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
        end
        // A rise in the latch cycle still opens bit 0 of the next frame.
        if (rise) begin
          state_d  = ST_HIGH;
          hi_cnt_d = '0;
        end else if (lo_cnt_q != LO_FULL) begin
          lo_cnt_d = lo_cnt_q + LO_W'(1);
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d  = ST_LOW;
          lo_cnt_d = '0;
          if (hi_len < HI_MIN) begin
            err_set = 1'b1;
          end else begin
            shift_d = shift_nxt;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              if (pix_cnt_q == PIX_MAX) begin
                err_set = 1'b1;
              end else begin
                pixel_d       = pixel_t'(shift_nxt);
                pixel_index_d = pix_cnt_q[IDX_W-1:0];
                pixel_valid_d = 1'b1;
                pix_cnt_d     = pix_cnt_q + CNT_W'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end else if (hi_len >= HI_MAX) begin
          state_d   = ST_SYNC;
          lo_cnt_d  = '0;
          bit_cnt_d = '0;
          err_set   = 1'b1;
        end else begin
          hi_cnt_d = hi_len;
        end
      end

      default: state_d = ST_SYNC;
    endcase

    err_d = err_set | (err_q & ~frame_done_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SYNC;
      lo_cnt_q      <= '0;
      hi_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      shift_q       <= '0;
      pixel_q       <= '0;
      pixel_index_q <= '0;
      pixel_count_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_cnt_q      <= lo_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      shift_q       <= shift_d;
      pixel_q       <= pixel_d;
      pixel_index_q <= pixel_index_d;
      pixel_count_q <= pixel_count_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign pixel_count = pixel_count_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;

endmodule
